// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit adder/subtractor with the carry chain cut into
//                STAGES registered segments, valid/ready stream handshake on
//                both sides, full backpressure and signed-overflow flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    // Segment width; guarded so a bad STAGES still reaches the check below.
    localparam int c_seg  = (STAGES >= 1) ? (WIDTH / STAGES) : 1;
    localparam int c_last = (STAGES >= 1) ? (STAGES - 1) : 0;

    if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) || ((WIDTH % STAGES) != 0)) begin : g_bad_params
        $error("pipelined_adder: need WIDTH>=1, 1<=STAGES<=WIDTH and WIDTH divisible by STAGES");
    end

    // Per-stage pipeline registers. Each stage carries the full operand
    // words (upper segments still to be added) and the full partial sum
    // (lower segments already finished), so all fields stay aligned.
    logic             r_v   [STAGES];
    logic [WIDTH-1:0] r_a   [STAGES];
    logic [WIDTH-1:0] r_b   [STAGES];
    logic [WIDTH-1:0] r_sum [STAGES];
    logic             r_c   [STAGES];

    // Inputs seen by each stage's segment adder, and what it produces.
    logic             w_src_v   [STAGES];
    logic [WIDTH-1:0] w_src_a   [STAGES];
    logic [WIDTH-1:0] w_src_b   [STAGES];
    logic [WIDTH-1:0] w_src_sum [STAGES];
    logic             w_src_c   [STAGES];
    logic [c_seg:0]   w_seg     [STAGES];
    logic [WIDTH-1:0] w_nxt_sum [STAGES];

    logic [WIDTH-1:0] w_beff;
    logic             w_advance;
    logic             w_unused;

    // Subtraction is a + ~b + 1; the +1 enters as carry-in of segment 0.
    assign w_beff    = sub ? ~b : b;

    // The whole pipeline moves together; it only freezes when a finished
    // result is waiting on a stalled consumer.
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Route stage inputs: stage 0 from the ports, later stages from the
    // previous stage's registers.
    always_comb begin
        w_src_v[0]   = in_valid;
        w_src_a[0]   = a;
        w_src_b[0]   = w_beff;
        w_src_sum[0] = '0;
        w_src_c[0]   = sub;
        for (int k = 1; k < STAGES; k++) begin
            w_src_v[k]   = r_v[k-1];
            w_src_a[k]   = r_a[k-1];
            w_src_b[k]   = r_b[k-1];
            w_src_sum[k] = r_sum[k-1];
            w_src_c[k]   = r_c[k-1];
        end
    end

    // Segment adders: stage k resolves bits [k*c_seg +: c_seg] only.
    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            w_seg[k] = {1'b0, w_src_a[k][k*c_seg +: c_seg]}
                     + {1'b0, w_src_b[k][k*c_seg +: c_seg]}
                     + {{c_seg{1'b0}}, w_src_c[k]};
            w_nxt_sum[k] = w_src_sum[k];
            w_nxt_sum[k][k*c_seg +: c_seg] = w_seg[k][c_seg-1:0];
        end
    end

    // Pipeline registers: cleared on reset, shift together on advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= 1'b0;
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
                r_c[k]   <= 1'b0;
            end
        end else if (w_advance) begin
            for (int k = 0; k < STAGES; k++) begin
                r_v[k]   <= w_src_v[k];
                r_a[k]   <= w_src_a[k];
                r_b[k]   <= w_src_b[k];
                r_sum[k] <= w_nxt_sum[k];
                r_c[k]   <= w_seg[k][c_seg];
            end
        end
    end

    // Outputs come straight from the last stage; overflow uses the operand
    // sign bits that travelled with the same transaction.
    assign out_valid = r_v[c_last];
    assign sum       = r_sum[c_last];
    assign carry     = r_c[c_last];
    assign overflow  = (r_a[c_last][WIDTH-1] == r_b[c_last][WIDTH-1]) &&
                       (r_sum[c_last][WIDTH-1] != r_a[c_last][WIDTH-1]);

    // Segments already consumed by earlier stages are intentionally dropped.
    always_comb begin
        w_unused = 1'b0;
        for (int k = 0; k < STAGES; k++) begin
            w_unused = w_unused ^ (^r_a[k]) ^ (^r_b[k]) ^ (^r_sum[k]) ^ r_c[k] ^ r_v[k];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Directed self-checking bench for pipelined_adder: reset,
//                add/subtract flags, backpressure, mid-flight reset, and an
//                exhaustive WIDTH=4 sweep for STAGES = 1, 2, 4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;

    int total = 0;
    int bad   = 0;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'h00;
    logic [7:0] b = 8'h00;
    logic       sub = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] sum;
    logic       carry;
    logic       overflow;

    // Sweep instances: index 0/1/2 -> STAGES 1/2/4, WIDTH 4.
    logic       sw_iv   [3];
    logic       sw_ir   [3];
    logic [3:0] sw_a    [3];
    logic [3:0] sw_b    [3];
    logic       sw_sub  [3];
    logic       sw_ov   [3];
    logic       sw_ordy [3];
    logic [3:0] sw_sum  [3];
    logic       sw_c    [3];
    logic       sw_o    [3];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .overflow  (overflow)
    );

    for (genvar s = 0; s < 3; s++) begin : g_sw
        pipelined_adder #(.WIDTH(4), .STAGES((s == 0) ? 1 : ((s == 1) ? 2 : 4))) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sw_iv[s]),
            .in_ready  (sw_ir[s]),
            .a         (sw_a[s]),
            .b         (sw_b[s]),
            .sub       (sw_sub[s]),
            .out_valid (sw_ov[s]),
            .out_ready (sw_ordy[s]),
            .sum       (sw_sum[s]),
            .carry     (sw_c[s]),
            .overflow  (sw_o[s])
        );
    end

    function automatic int stg_of(input int s);
        return (s == 0) ? 1 : ((s == 1) ? 2 : 4);
    endfunction

    // 4-bit reference: {sum, carry, overflow} from integer arithmetic.
    function automatic logic [5:0] ref4(input logic [3:0] x, input logic [3:0] y, input logic s);
        int         sx;
        int         sy;
        int         r;
        logic       c;
        logic [3:0] sm;
        sx = int'(x) - (x[3] ? 16 : 0);
        sy = int'(y) - (y[3] ? 16 : 0);
        r  = s ? (sx - sy) : (sx + sy);
        sm = s ? 4'(x - y) : 4'(x + y);
        c  = s ? (x >= y) : ((int'(x) + int'(y)) > 15);
        return {sm, c, ((r > 7) || (r < -8))};
    endfunction

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (sum !== 8'h00) begin bad++; $display("FAIL reset_sum got=%h want=00", sum); end
        total++; if (carry !== 1'b0) begin bad++; $display("FAIL reset_carry got=%b want=0", carry); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_arith;
        // {a, b, sub, sum, carry, overflow}
        logic [26:0] vec [7];
        logic [26:0] v;
        logic [9:0]  got;
        vec[0] = {8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[1] = {8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vec[2] = {8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0};
        vec[3] = {8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        vec[4] = {8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vec[5] = {8'h3C, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0};
        vec[6] = {8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            v = vec[i];
            @(negedge clk);
            in_valid  = 1'b1;
            a         = v[26:19];
            b         = v[18:11];
            sub       = v[10];
            out_ready = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL arith_early_valid case=%0d got=%b want=0", i, out_valid);
            end
            @(negedge clk);
            got = {out_valid, sum, carry, overflow} >> 0;
            total++;
            if ({out_valid, sum, carry, overflow} !== {1'b1, v[9:0]}) begin
                bad++;
                $display("FAIL arith case=%0d got v=%b sum=%h c=%b o=%b want v=1 sum=%h c=%b o=%b",
                         i, out_valid, sum, carry, overflow, v[9:2], v[1], v[0]);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        int next_in  = 1;
        int next_out = 1;
        int stall    = 0;
        int cyc      = 0;
        bit seen     = 1'b0;
        while (next_out <= 5 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            in_valid  = (next_in <= 5);
            a         = 8'(next_in);
            b         = 8'h10;
            sub       = 1'b0;
            #1;
            if (stall > 0) begin
                stall--;
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 8'h11) begin
                    bad++;
                    $display("FAIL bp_stall got in_ready=%b out_valid=%b sum=%h want 0 1 11", in_ready, out_valid, sum);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (sum !== 8'(16 + next_out)) begin
                    bad++;
                    $display("FAIL bp_order idx=%0d got=%h want=%h", next_out, sum, 8'(16 + next_out));
                end
                next_out++;
            end
            if (in_valid && in_ready) next_in++;
        end
        total++;
        if (next_out != 6) begin
            bad++; $display("FAIL bp_count got=%0d want=5 (timeout)", next_out - 1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL bp_duplicate got out_valid=%b sum=%h want out_valid=0", out_valid, sum);
            end
        end
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        a = 8'h21; b = 8'h01; sub = 1'b0;
        @(negedge clk);
        a = 8'h31; b = 8'h02;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++; $display("FAIL midreset_at_edge got out_valid=%b want=0", out_valid);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (out_valid !== 1'b0) begin
                bad++; $display("FAIL midreset_leak cyc=%0d got out_valid=%b sum=%h want out_valid=0", i, out_valid, sum);
            end
        end
    endtask

    task automatic test_sweep(input int s);
        logic [5:0] q[$];
        logic [5:0] want;
        logic [5:0] got;
        int         idx = 0;
        int         cyc = 0;
        int         lat = 0;
        logic [8:0] iv;
        // Latency on an idle pipeline with the consumer always ready.
        @(negedge clk);
        sw_ordy[s] = 1'b1;
        sw_iv[s]   = 1'b1;
        sw_a[s]    = 4'd3;
        sw_b[s]    = 4'd4;
        sw_sub[s]  = 1'b0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            sw_iv[s] = 1'b0;
        end while (!sw_ov[s] && lat < 10);
        total++;
        if (lat != stg_of(s)) begin
            bad++; $display("FAIL sweep_latency stages=%0d got=%0d want=%0d", stg_of(s), lat, stg_of(s));
        end
        total++;
        if ({sw_sum[s], sw_c[s], sw_o[s]} !== 6'b0111_0_0) begin
            bad++; $display("FAIL sweep_latency_value stages=%0d got=%b want=011100", stg_of(s), {sw_sum[s], sw_c[s], sw_o[s]});
        end
        // Exhaustive vectors with random valid/ready.
        while ((idx < 512 || q.size() != 0) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            sw_ordy[s] = ($urandom_range(0, 3) != 0);
            if (idx < 512) begin
                iv         = 9'(idx);
                sw_iv[s]   = ($urandom_range(0, 3) != 0);
                sw_a[s]    = iv[3:0];
                sw_b[s]    = iv[7:4];
                sw_sub[s]  = iv[8];
            end else begin
                sw_iv[s] = 1'b0;
            end
            #1;
            if (sw_ov[s] && sw_ordy[s]) begin
                got = {sw_sum[s], sw_c[s], sw_o[s]};
                total++;
                if (q.size() == 0) begin
                    bad++; $display("FAIL sweep_extra stages=%0d got=%b want=no output", stg_of(s), got);
                end else begin
                    want = q.pop_front();
                    if (got !== want) begin
                        bad++; $display("FAIL sweep stages=%0d got=%b want=%b", stg_of(s), got, want);
                    end
                end
            end
            if (sw_iv[s] && sw_ir[s]) begin
                q.push_back(ref4(sw_a[s], sw_b[s], sw_sub[s]));
                idx++;
            end
        end
        total++;
        if (idx != 512 || q.size() != 0) begin
            bad++; $display("FAIL sweep_timeout stages=%0d sent=%0d pending=%0d want sent=512 pending=0", stg_of(s), idx, q.size());
        end
        sw_iv[s]   = 1'b0;
        sw_ordy[s] = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < 3; s++) begin
            sw_iv[s] = 1'b0; sw_ordy[s] = 1'b1;
            sw_a[s] = 4'd0; sw_b[s] = 4'd0; sw_sub[s] = 1'b0;
        end
        test_reset;
        test_arith;
        test_backpressure;
        test_reset_midflight;
        for (int s = 0; s < 3; s++) test_sweep(s);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
